single_loop: RTL and testbench
==============================

Name: single_loop

Overview:
- Hardware loop-iteration tracker for the control unit's pre-queue stage, one instance per active loop.
- Counts how many iterations of a loop body have been issued and raises `done` while the final iteration is in flight, so the end-loop instruction falls through instead of jumping back.
- Supports two modes. In normal mode each iteration is issued one at a time. In inner-independent mode, 2^SUPERSCALAR_LOG_WIDTH iterations are issued per pass.

Parameters:
- BITS, 15, width of the iteration count and of current_iteration.
- SUPERSCALAR_LOG_WIDTH, 2, log2 of iterations issued per pass in independent mode (step = 4 by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- should_increment  input  1  enables counting; 0 freezes the counter.
- initial_iteration_count  input  BITS  total iterations of the loop; captured once after reset release.
- jumped  input  1  end-loop instruction took its backward jump this cycle.
- initial_is_inner_independent_loop  input  1  selects independent mode; captured with the count.
- done  output  1  the last iteration (or last pass) is in progress.
- current_iteration  output  BITS  index of the first iteration of the current pass.

Behaviour:
- Reset (reset==0, asynchronous): current_iteration=0, loaded=0, count_q=0, mode_q=0.
  - During reset, done is combinational from the live inputs (see the done rule).
- Configuration capture:
  - On the first rising edge with reset==1 and loaded==0: count_q<=initial_iteration_count, mode_q<=initial_is_inner_independent_loop, loaded<=1.
  - After that, these inputs are ignored until the next reset.
- Effective values:
  - eff_count = loaded ? count_q : initial_iteration_count.
  - eff_mode = loaded ? mode_q : initial_is_inner_independent_loop.
  - step = eff_mode ? 2^SUPERSCALAR_LOG_WIDTH : 1.
- done, combinational: done = (current_iteration + step >= eff_count).
  - Compute in BITS+1 bits so the sum cannot wrap.
  - eff_count==0 gives done=1.
- Counting, per rising edge out of reset:
  - If should_increment && jumped && !done: current_iteration <= current_iteration + step.
  - Otherwise hold.
  - This also applies on the capture edge, using the effective values.
- Saturation: once done=1, further jumps do not advance the counter, so current_iteration never exceeds eff_count-1 in normal mode.
- Latency:
  - One jump pulse sampled on one edge gives exactly one increment.
  - A jump held for N edges gives N increments, stopping at done.
- Mid-operation reset: everything returns to the reset state immediately, and the next configuration is captured on the first edge after release.
- done is never registered. It updates in the same cycle as current_iteration and the effective values.

Decomposition:
- Shared control-unit package holds:
  - localparam function/constant for the lane count, 1<<SUPERSCALAR_LOG_WIDTH;
  - a typedef for an iteration index of width BITS.
- No sub-module. Counter, capture registers and comparator fit in one always_ff plus one always_comb.

Test Plan:
- Normal, count=3, mode=0, should_increment=1:
  - two single-cycle jumps separated by idle cycles -> current_iteration 0→1→2;
  - done=0 before the second jump and done=1 after it.
- Independent, count=2, mode=1, no jump -> done=1 immediately after the capture edge (0+4>=2), current_iteration=0.
- Independent, count=16, mode=1:
  - jumped held high for 3 edges -> current_iteration 0→4→8→12;
  - done=0 at 0, 4 and 8, done=1 at 12;
  - a 4th held edge leaves current_iteration at 12.
- should_increment=0 with jumped=1 for 5 edges -> current_iteration stays 0, done unchanged.
- Reset asserted mid-loop at current_iteration=8, then released with count=3, mode=0 -> current_iteration=0 asynchronously, and the new count is captured (done only at 2).
- count=0 -> done=1 from reset release; jumps never change current_iteration.

Source files
------------

// File: rtl/single_loop_pkg.sv
// Shared control-unit definitions for the loop-iteration tracker:
// superscalar lane count helper and the default iteration-index type.
package single_loop_pkg;

  localparam int SL_BITS = 15;
  localparam int SL_SUPERSCALAR_LOG_WIDTH = 2;

  typedef logic [SL_BITS-1:0] iter_idx_t;

  // Iterations issued per pass when the loop body is inner-independent.
  function automatic int lane_count(input int log_width);
    return 1 << log_width;
  endfunction

endpackage : single_loop_pkg

// File: rtl/single_loop.sv
// Loop-iteration tracker: counts issued iterations (1 or a lane-width per pass)
// and raises done while the final iteration/pass is in flight.
module single_loop
  import single_loop_pkg::*;
#(
  parameter int BITS                  = SL_BITS,
  parameter int SUPERSCALAR_LOG_WIDTH = SL_SUPERSCALAR_LOG_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            should_increment,
  input  logic [BITS-1:0] initial_iteration_count,
  input  logic            jumped,
  input  logic            initial_is_inner_independent_loop,
  output logic            done,
  output logic [BITS-1:0] current_iteration
);

  localparam int LANES = lane_count(SUPERSCALAR_LOG_WIDTH);

  logic [BITS-1:0] cur_q, cur_d;
  logic [BITS-1:0] count_q;
  logic            mode_q;
  logic            loaded_q;

  logic [BITS-1:0] eff_count;
  logic            eff_mode;
  logic [BITS:0]   step;
  logic [BITS:0]   sum;
  logic            done_c;

  // Before capture the live inputs stand in for the not-yet-loaded registers,
  // so done and the capture-edge increment already see the configuration.
  always_comb begin
    eff_count = initial_iteration_count;
    eff_mode  = initial_is_inner_independent_loop;
    if (loaded_q) begin
      eff_count = count_q;
      eff_mode  = mode_q;
    end
    step   = eff_mode ? (BITS+1)'(LANES) : (BITS+1)'(1);
    sum    = {1'b0, cur_q} + step;
    done_c = (sum >= {1'b0, eff_count});
    cur_d  = cur_q;
    // sum < eff_count whenever done is low, so truncation is lossless here.
    if (should_increment && jumped && !done_c) begin
      cur_d = sum[BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q    <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      if (!loaded_q) begin
        count_q  <= initial_iteration_count;
        mode_q   <= initial_is_inner_independent_loop;
        loaded_q <= 1'b1;
      end
    end
  end

  assign done              = done_c;
  assign current_iteration = cur_q;

endmodule : single_loop

// File: tb/tb_single_loop.sv
// Scoreboard bench for single_loop: expected state is pushed per driven cycle
// and popped/compared one step after the following rising edge.
module tb_single_loop;
  import single_loop_pkg::*;

  localparam int BITS  = SL_BITS;
  localparam int LANES = 4;

  logic            clk;
  logic            reset;
  logic            should_increment;
  logic [BITS-1:0] initial_iteration_count;
  logic            jumped;
  logic            initial_is_inner_independent_loop;
  logic            done;
  logic [BITS-1:0] current_iteration;

  single_loop #(.BITS(BITS), .SUPERSCALAR_LOG_WIDTH(2)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .should_increment                  (should_increment),
    .initial_iteration_count           (initial_iteration_count),
    .jumped                            (jumped),
    .initial_is_inner_independent_loop (initial_is_inner_independent_loop),
    .done                              (done),
    .current_iteration                 (current_iteration)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cur;
    int dn;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_cur;
  int m_count;
  int m_mode;
  int m_loaded;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_done();
    int ec, em, st;
    ec = m_loaded ? m_count : int'(initial_iteration_count);
    em = m_loaded ? m_mode  : int'(initial_is_inner_independent_loop);
    st = em ? LANES : 1;
    return (m_cur + st >= ec) ? 1 : 0;
  endfunction

  // Assert reset mid-cycle with a new configuration and check the async effect.
  task automatic apply_reset(input int cnt, input int mode, input string tag);
    #2;
    reset = 1'b0;
    initial_iteration_count = BITS'(cnt);
    initial_is_inner_independent_loop = mode[0];
    m_cur = 0; m_count = 0; m_mode = 0; m_loaded = 0;
    #1;
    check({tag, ".rst_cur"}, int'(current_iteration), 0);
    check({tag, ".rst_done"}, int'(done), model_done());
  endtask

  // One clock cycle: drive, update model, push expectation, then pop and compare.
  task automatic cycle(input logic sinc, input logic jmp, input string tag);
    exp_t e;
    int d;
    @(negedge clk);
    reset = 1'b1;
    should_increment = sinc;
    jumped = jmp;
    d = model_done();
    if (sinc && jmp && d == 0) begin
      m_cur += ((m_loaded ? m_mode : int'(initial_is_inner_independent_loop)) != 0) ? LANES : 1;
    end
    if (m_loaded == 0) begin
      m_count  = int'(initial_iteration_count);
      m_mode   = int'(initial_is_inner_independent_loop);
      m_loaded = 1;
    end
    e.cur = m_cur;
    e.dn  = model_done();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".cur"}, int'(current_iteration), e.cur);
    check({tag, ".done"}, int'(done), e.dn);
    $display("txn %s: sinc=%0b jmp=%0b cur=%0d done=%0b", tag, sinc, jmp,
             current_iteration, done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    should_increment = 1'b0;
    jumped = 1'b0;
    initial_iteration_count = '0;
    initial_is_inner_independent_loop = 1'b0;
    m_cur = 0; m_count = 0; m_mode = 0; m_loaded = 0;
    repeat (2) @(posedge clk);

    // Normal mode, count=3: separated single-cycle jumps
    apply_reset(3, 0, "n3");
    cycle(1'b1, 1'b0, "n3.cap");
    cycle(1'b1, 1'b1, "n3.j1");
    cycle(1'b1, 1'b0, "n3.idle");
    cycle(1'b1, 1'b1, "n3.j2");
    cycle(1'b1, 1'b1, "n3.sat");

    // Independent, count=2: done immediately
    apply_reset(2, 1, "i2");
    cycle(1'b1, 1'b0, "i2.cap");
    cycle(1'b1, 1'b1, "i2.jmp");

    // Independent, count=16: held jump steps by 4 and saturates at 12
    apply_reset(16, 1, "i16");
    cycle(1'b1, 1'b0, "i16.cap");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, $sformatf("i16.h%0d", i));

    // should_increment low freezes the counter
    apply_reset(5, 0, "frz");
    cycle(1'b1, 1'b0, "frz.cap");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, $sformatf("frz.%0d", i));

    // Mid-loop reset at 8, then new configuration; later input changes ignored
    apply_reset(16, 1, "mid");
    cycle(1'b1, 1'b0, "mid.cap");
    cycle(1'b1, 1'b1, "mid.j1");
    cycle(1'b1, 1'b1, "mid.j2");
    apply_reset(3, 0, "mid.re");
    cycle(1'b1, 1'b0, "mid.cap2");
    initial_iteration_count = BITS'(100);
    initial_is_inner_independent_loop = 1'b1;
    cycle(1'b1, 1'b1, "mid.k1");
    cycle(1'b1, 1'b1, "mid.k2");
    cycle(1'b1, 1'b1, "mid.k3");

    // count=0: done from reset and jumps never move the counter
    apply_reset(0, 0, "z");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, $sformatf("z.%0d", i));

    check("sb.empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_single_loop
